// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - MIPS coprocessor-0: SR/Cause/EPC/BadVAddr/PRId, optional Count/Compare timer
//
// Purpose:
//   Sits beside the M stage. Arbitrates interrupt versus exception, raises req
//   and supplies the handler-return PC (epc_out). Services mfc0 (cp0_out, a
//   combinational read) and mtc0 (en/cp0_addr/cp0_in).
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   en                mtc0 write enable
//   cp0_addr[4:0]     register index for read and write
//   cp0_in[31:0]      mtc0 data
//   cp0_out[31:0]     combinational read of register cp0_addr
//   vpc[31:0]         PC of the victim instruction in M
//   bd_in             victim is in a delay slot
//   exc_code_in[4:0]  exception code, 0 = none
//   bad_vaddr_in      faulting address for AdEL/AdES (codes 4/5)
//   hw_int            external interrupt levels (NUM_HWINT bits)
//   exl_clr           eret in M
//   epc_out[31:0]     handler-return PC, word aligned
//   req               take interrupt/exception this cycle
//
// Configuration:
//   CP0_TIMER_EN      when defined, implements Count (9), Compare (11) and TI.
//                     When undefined, regs 9/11 read 0 and TI is constant 0.

module cp0_unit #(
    parameter int          NUM_HWINT  = 6,
    parameter int          TIMER_LINE = 5,
    parameter int          COUNT_DIV  = 1,
    parameter logic [31:0] PRID       = 32'h0000_0724
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [4:0]           cp0_addr,
    input  logic [31:0]          cp0_in,
    output logic [31:0]          cp0_out,
    input  logic [31:0]          vpc,
    input  logic                 bd_in,
    input  logic [4:0]           exc_code_in,
    input  logic [31:0]          bad_vaddr_in,
    input  logic [NUM_HWINT-1:0] hw_int,
    input  logic                 exl_clr,
    output logic [31:0]          epc_out,
    output logic                 req
);

    // Only the implemented interrupt lines may be enabled; the rest read 0.
    localparam logic [5:0] IM_MASK = 6'((1 << NUM_HWINT) - 1);

    localparam logic [4:0] A_BADVADDR = 5'd8;
    localparam logic [4:0] A_COUNT    = 5'd9;
    localparam logic [4:0] A_COMPARE  = 5'd11;
    localparam logic [4:0] A_SR       = 5'd12;
    localparam logic [4:0] A_CAUSE    = 5'd13;
    localparam logic [4:0] A_EPC      = 5'd14;
    localparam logic [4:0] A_PRID     = 5'd15;

    logic [31:0] bad_vaddr_q, bad_vaddr_d;
    logic [31:0] epc_q, epc_d;
    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic        cause_ti_q, cause_ti_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_code_q, exc_code_d;

    logic        ti;
    logic [5:0]  pend6;
    logic        int_req;
    logic        exc_req;
    logic        wr_en;
    logic [31:0] epc_sel;
    logic [31:0] epc_next;

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;
    logic [7:0]  presc_q, presc_d;
    logic        count_upd;

    assign ti = ti_q;
`else
    logic unused_timer_cfg;

    assign ti = 1'b0;
    assign unused_timer_cfg = ^{8'(COUNT_DIV), 8'(TIMER_LINE)};
`endif

    // Pending vector, zero-extended to the 6-bit IP field.
    always_comb begin
        pend6 = '0;
        pend6[NUM_HWINT-1:0] = hw_int;
`ifdef CP0_TIMER_EN
        pend6[TIMER_LINE] = pend6[TIMER_LINE] | ti;
`endif
    end

    assign int_req  = (|(pend6 & im_q)) & ie_q & ~exl_q;
    assign exc_req  = (exc_code_in != 5'd0) & ~exl_q;
    assign req      = int_req | exc_req;
    // A taken request swallows any mtc0 issued in the same cycle.
    assign wr_en    = en & ~req;
    assign epc_sel  = bd_in ? (vpc - 32'd4) : vpc;
    assign epc_next = {epc_sel[31:2], 2'b00};
    assign epc_out  = req ? epc_next : epc_q;

    always_comb begin
        cp0_out = 32'd0;
        case (cp0_addr)
            A_BADVADDR: cp0_out = bad_vaddr_q;
`ifdef CP0_TIMER_EN
            A_COUNT:    cp0_out = count_q;
            A_COMPARE:  cp0_out = compare_q;
`endif
            A_SR:       cp0_out = {16'd0, im_q, 8'd0, exl_q, ie_q};
            A_CAUSE:    cp0_out = {bd_q, cause_ti_q, 14'd0, ip_q, 3'd0, exc_code_q, 2'd0};
            A_EPC:      cp0_out = epc_q;
            A_PRID:     cp0_out = PRID;
            default:    cp0_out = 32'd0;
        endcase
    end

    always_comb begin
        bad_vaddr_d = bad_vaddr_q;
        epc_d       = epc_q;
        im_d        = im_q;
        exl_d       = exl_q;
        ie_d        = ie_q;
        bd_d        = bd_q;
        exc_code_d  = exc_code_q;
        ip_d        = pend6;
        cause_ti_d  = ti;

        if (exl_clr) begin
            exl_d = 1'b0;
        end

        if (req) begin
            exc_code_d = int_req ? 5'd0 : exc_code_in;
            exl_d      = 1'b1;
            epc_d      = epc_next;
            bd_d       = bd_in;
            if (!int_req && (exc_code_in == 5'd4 || exc_code_in == 5'd5)) begin
                bad_vaddr_d = bad_vaddr_in;
            end
        end else if (en) begin
            case (cp0_addr)
                A_SR: begin
                    im_d  = cp0_in[15:10] & IM_MASK;
                    exl_d = cp0_in[1];
                    ie_d  = cp0_in[0];
                end
                A_EPC:   epc_d = {cp0_in[31:2], 2'b00};
                default: ;
            endcase
        end
    end

`ifdef CP0_TIMER_EN
    // Timer: a write to Count beats the same-cycle increment and restarts the
    // prescaler; a write to Compare clears TI outright.
    always_comb begin
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        presc_d   = presc_q;
        count_upd = 1'b0;

        if (presc_q == 8'(COUNT_DIV - 1)) begin
            presc_d   = 8'd0;
            count_d   = count_q + 32'd1;
            count_upd = 1'b1;
        end else begin
            presc_d = presc_q + 8'd1;
        end

        if (wr_en && cp0_addr == A_COUNT) begin
            count_d   = cp0_in;
            presc_d   = 8'd0;
            count_upd = 1'b1;
        end

        if (wr_en && cp0_addr == A_COMPARE) begin
            compare_d = cp0_in;
            ti_d      = 1'b0;
        end else if (count_upd && count_d == compare_q) begin
            ti_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            ti_q      <= 1'b0;
            presc_q   <= 8'd0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
            presc_q   <= presc_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            bad_vaddr_q <= 32'd0;
            epc_q       <= 32'd0;
            im_q        <= 6'd0;
            exl_q       <= 1'b0;
            ie_q        <= 1'b0;
            bd_q        <= 1'b0;
            cause_ti_q  <= 1'b0;
            ip_q        <= 6'd0;
            exc_code_q  <= 5'd0;
        end else begin
            bad_vaddr_q <= bad_vaddr_d;
            epc_q       <= epc_d;
            im_q        <= im_d;
            exl_q       <= exl_d;
            ie_q        <= ie_d;
            bd_q        <= bd_d;
            cause_ti_q  <= cause_ti_d;
            ip_q        <= ip_d;
            exc_code_q  <= exc_code_d;
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - self-checking bench for cp0_unit with a word-level reference model
`timescale 1ns/1ps

module tb_cp0_unit;

    localparam logic [31:0] PRID = 32'h0000_0724;
    localparam int          TL   = 5;
    localparam int          DIV  = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_in;
    logic [31:0] cp0_out;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [31:0] bad_vaddr_in;
    logic [5:0]  hw_int;
    logic        exl_clr;
    logic [31:0] epc_out;
    logic        req;

    cp0_unit #(.NUM_HWINT(6), .TIMER_LINE(TL), .COUNT_DIV(DIV), .PRID(PRID)) dut (
        .clk(clk), .reset(reset), .en(en), .cp0_addr(cp0_addr), .cp0_in(cp0_in),
        .cp0_out(cp0_out), .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in),
        .bad_vaddr_in(bad_vaddr_in), .hw_int(hw_int), .exl_clr(exl_clr),
        .epc_out(epc_out), .req(req)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural state as whole 32-bit words.
    logic [31:0] m_sr = 0, m_cause = 0, m_epc = 0, m_badv = 0;
    logic [31:0] m_count = 0, m_compare = 0;
    bit          m_ti = 0;
    int          m_presc = 0;

    function automatic logic [5:0] m_pend();
        logic [5:0] p;
        p = hw_int;
`ifdef CP0_TIMER_EN
        if (m_ti) p = p | (6'd1 << TL);
`endif
        return p;
    endfunction

    function automatic bit m_int_req();
        return ((m_pend() & m_sr[15:10]) != 0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic bit m_req();
        return m_int_req() || (exc_code_in != 0 && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_epc_next();
        logic [31:0] v;
        v = bd_in ? vpc - 32'd4 : vpc;
        return v & ~32'd3;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:  return m_badv;
`ifdef CP0_TIMER_EN
            5'd9:  return m_count;
            5'd11: return m_compare;
`endif
            5'd12: return m_sr;
            5'd13: return m_cause;
            5'd14: return m_epc;
            5'd15: return PRID;
            default: return 32'd0;
        endcase
    endfunction

    logic [5:0]  mp;
    bit          mir, mrq, mwr, mupd;
    logic [31:0] mepcn, mnc;

    always @(posedge clk) begin
        if (reset) begin
            m_sr = 0; m_cause = 0; m_epc = 0; m_badv = 0;
            m_count = 0; m_compare = 0; m_ti = 0; m_presc = 0;
        end else begin
            mp    = m_pend();
            mir   = m_int_req();
            mrq   = m_req();
            mepcn = m_epc_next();
            mwr   = en && !mrq;
            m_cause = (m_cause & 32'h8000_007C) | (32'(mp) << 10) | (32'(m_ti) << 30);
            if (exl_clr) m_sr[1] = 1'b0;
            if (mrq) begin
                m_cause[6:2] = mir ? 5'd0 : exc_code_in;
                m_cause[31]  = bd_in;
                m_sr[1]      = 1'b1;
                m_epc        = mepcn;
                if (!mir && (exc_code_in == 4 || exc_code_in == 5)) m_badv = bad_vaddr_in;
            end else if (en) begin
                if (cp0_addr == 12) m_sr = cp0_in & 32'h0000_FC03;
                if (cp0_addr == 14) m_epc = cp0_in & ~32'd3;
            end
`ifdef CP0_TIMER_EN
            mupd = 1'b0;
            mnc  = m_count;
            if (m_presc == DIV - 1) begin
                m_presc = 0; mnc = m_count + 1; mupd = 1'b1;
            end else begin
                m_presc++;
            end
            if (mwr && cp0_addr == 9) begin
                mnc = cp0_in; m_presc = 0; mupd = 1'b1;
            end
            if (mwr && cp0_addr == 11) begin
                m_compare = cp0_in; m_ti = 0;
            end else if (mupd && mnc == m_compare) begin
                m_ti = 1;
            end
            m_count = mnc;
`endif
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc_req", 32'(req), 32'(m_req()));
            chk("cyc_epc_out", epc_out, m_req() ? m_epc_next() : m_epc);
            chk("cyc_cp0_out", cp0_out, m_read(cp0_addr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input string name, input logic [31:0] exp);
        cp0_addr = a;
        #1;
        chk(name, cp0_out, exp);
    endtask

    logic [4:0] addr_tab [7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};

    initial begin
        reset = 1; en = 0; cp0_addr = 0; cp0_in = 0; vpc = 0; bd_in = 0;
        exc_code_in = 0; bad_vaddr_in = 0; hw_int = 6'h3F; exl_clr = 0;
        step(); step();
        cmp_on = 1'b1;
        rd(12, "rst_sr", 32'd0);
        rd(15, "rst_prid", PRID);
        chk("rst_req", 32'(req), 32'd0);
        step(); reset = 0; cp0_addr = 13;
        step(); #1;
        chk("rst_ip", 32'(cp0_out[15:10]), 32'h3F);

        // Interrupt through IM[11] from a delay slot.
        hw_int = 0; en = 1; cp0_addr = 12; cp0_in = 32'h0000_0C01;
        step(); en = 0; hw_int = 6'h02; vpc = 32'h3008; bd_in = 1; #1;
        chk("int_req", 32'(req), 32'd1);
        chk("int_epc_out", epc_out, 32'h3004);
        step(); bd_in = 0;
        rd(14, "int_epc", 32'h3004);
        rd(13, "int_cause", 32'h8000_0800);
        rd(12, "int_sr", 32'h0000_0C03);
        chk("int_req_after", 32'(req), 32'd0);

        // Address-error exception with a colliding mtc0 EPC.
        step(); hw_int = 0; en = 1; cp0_addr = 12; cp0_in = 32'h0000_0C00;
        step(); cp0_addr = 14; cp0_in = 32'hDEAD_BEEF; exc_code_in = 4;
        bad_vaddr_in = 32'h0000_1001; vpc = 32'h3010; #1;
        chk("exc_req", 32'(req), 32'd1);
        chk("exc_epc_out", epc_out, 32'h3010);
        step(); en = 0; exc_code_in = 0; cp0_addr = 13; #1;
        chk("exc_code", 32'(cp0_out[6:2]), 32'd4);
        rd(8, "exc_badv", 32'h0000_1001);
        rd(14, "exc_epc", 32'h3010);

        // EXL blocks, eret releases.
        step(); exc_code_in = 10; #1;
        chk("exl_block", 32'(req), 32'd0);
        step(); exl_clr = 1; #1;
        chk("exl_block2", 32'(req), 32'd0);
        step(); exl_clr = 0; #1;
        chk("exl_clr_req", 32'(req), 32'd1);
        rd(12, "exl_sr", 32'h0000_0C00);
        step(); exc_code_in = 0; en = 1; cp0_addr = 12; cp0_in = 32'd0;
        step(); en = 0;

`ifdef CP0_TIMER_EN
        begin
            int n;
            en = 1; cp0_addr = 12; cp0_in = 32'h0000_8001;
            step(); cp0_addr = 9; cp0_in = 0;
            step(); cp0_addr = 11; cp0_in = 5;
            step(); en = 0;
            n = 0;
            while (!req && n < 20) begin
                step();
                n++;
            end
            chk("ti_req", 32'(req), 32'd1);
            rd(9, "ti_count", 32'd5);
            step();
            en = 1; cp0_addr = 11; cp0_in = 0;
            step(); en = 0;
            step(); cp0_addr = 13; #1;
            chk("ti_clr", 32'(cp0_out[30]), 32'd0);
            en = 1; cp0_addr = 9; cp0_in = 32'hFFFF_FFFF;
            step(); en = 0;
            rd(9, "count_max", 32'hFFFF_FFFF);
            step();
            rd(9, "count_wrap", 32'd0);
            step(); en = 1; cp0_addr = 12; cp0_in = 0;
            step(); en = 0;
        end
`else
        en = 1; cp0_addr = 11; cp0_in = 5;
        step(); cp0_addr = 9; cp0_in = 3;
        step(); cp0_addr = 12; cp0_in = 32'h0000_8001;
        step(); en = 0;
        rd(9, "noti_count", 32'd0);
        rd(11, "noti_compare", 32'd0);
        for (int i = 0; i < 40; i++) begin
            step();
            chk("noti_req", 32'(req), 32'd0);
        end
`endif

        for (int i = 0; i < 3000; i++) begin
            step();
            reset        = ($urandom_range(0, 199) == 0);
            hw_int       = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            en           = ($urandom_range(0, 2) == 0);
            cp0_addr     = ($urandom_range(0, 3) != 0) ? addr_tab[$urandom_range(0, 6)] : 5'($urandom);
            cp0_in       = (cp0_addr == 9 || cp0_addr == 11) ? $urandom_range(0, 40) : $urandom;
            exc_code_in  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'd0;
            bad_vaddr_in = $urandom;
            vpc          = $urandom;
            bd_in        = 1'($urandom);
            exl_clr      = ($urandom_range(0, 5) == 0);
        end
        step();
        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Parametrised coprocessor-0 for the P7/P8 MIPS pipeline; successor of the fixed 6-line SR/Cause/EPC block.
- Sits beside the M stage.
- Holds SR, Cause, EPC, BadVAddr, PRId and an optional Count/Compare timer.
- Arbitrates interrupt versus exception, produces the exception request and handler-return EPC, and services mfc0/mtc0.

Parameters:
- NUM_HWINT, 6, number of external interrupt lines (1..6); mapped to SR.IM/Cause.IP bits [10 +: NUM_HWINT]; unused IM/IP bits read 0.
- TIMER_LINE, 5, IP index (0..NUM_HWINT-1) that the timer interrupt ORs into.
- COUNT_DIV, 1, Count increments once every COUNT_DIV clocks (1..255).
- PRID, 32'h0000_0724, constant value of PRId (reg 15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- en  in  1  mtc0 write enable.
- cp0_addr  in  5  register index for read and write.
- cp0_in  in  32  mtc0 data.
- cp0_out  out  32  combinational read of the register at cp0_addr.
- vpc  in  32  PC of the victim instruction in M.
- bd_in  in  1  victim is in a delay slot.
- exc_code_in  in  5  exception code; 0 = none.
- bad_vaddr_in  in  32  faulting address for AdEL/AdES.
- hw_int  in  NUM_HWINT  external interrupt levels.
- exl_clr  in  1  eret in M.
- epc_out  out  32  handler-return PC, word aligned.
- req  out  1  take interrupt/exception this cycle.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high.
- Reset values: every register is 0 except PRId = PRID. Timer flag TI = 0 and prescaler = 0. Resulting outputs: req = 0, epc_out = 0, cp0_out = register contents.
- Register map:
  - 8 BadVAddr (read-only)
  - 9 Count
  - 11 Compare
  - 12 SR: IM[15:10], EXL[1], IE[0] writable; other bits read 0
  - 13 Cause: BD[31], TI[30], IP[15:10], ExcCode[6:2]; read-only
  - 14 EPC: writable, stored word-aligned
  - 15 PRId
  - Any other index reads 0; writes to it are ignored.
- Pending vector: pend = hw_int, with TI ORed into bit TIMER_LINE.
- Request logic (combinational):
  - int_req = |(pend & IM) & IE & !EXL.
  - exc_req = (exc_code_in != 0) & !EXL.
  - req = int_req | exc_req.
  - Interrupt wins over exception.
- epc_next: bd_in ? vpc-4 : vpc, low two bits forced to 0.
- epc_out: epc_next when req is high, otherwise EPC. Zero latency.
- Each edge, no reset:
  - Cause.IP <= pend; Cause.TI <= TI.
  - If exl_clr: EXL <= 0.
  - If req:
    - ExcCode <= int_req ? 0 : exc_code_in.
    - EXL <= 1, EPC <= epc_next, BD <= bd_in.
    - If exception (not interrupt) and code is 4 or 5: BadVAddr <= bad_vaddr_in.
    - The mtc0 write in the same cycle is dropped.
    - req's EXL set overrides exl_clr.
  - Else if en: write cp0_in to the register at cp0_addr, honouring the writable masks above.
- Timer:
  - The prescaler counts 0..COUNT_DIV-1. On wrap, Count <= Count+1 modulo 2^32; wrap-around is silent.
  - TI sets on the edge where Count's new value equals Compare, whether from increment or from an mtc0 to Count.
  - An mtc0 to Compare clears TI and updates Compare.
  - An mtc0 to Count overrides the same-cycle increment and resets the prescaler.
  - The timer runs regardless of EXL.
- Read-during-write: cp0_out shows the old value until the edge.

Optional Feature:
- Macro: CP0_TIMER_EN.
- Defined: the Count/Compare timer and TI are implemented as described.
- Undefined: regs 9 and 11 read 0, writes to them are ignored, TI is constant 0, and COUNT_DIV and TIMER_LINE are unused. All other behaviour is identical.

Test Plan:
- Reset with hw_int=6'h3F -> req=0, cp0_out(12)=0, cp0_out(15)=PRID. The cycle after reset releases, cp0_out(13)[15:10]=6'h3F.
- mtc0 SR=32'h0000_0C01, then hw_int[1]=1 with vpc=32'h3008, bd_in=1 -> req=1 and epc_out=32'h3004 in that cycle. Next cycle: EPC=32'h3004, Cause=32'h8000_0800 (BD set, IP[11] set, ExcCode 0), SR=32'h0000_0C03, req=0.
- SR.IE=0, exc_code_in=4, bad_vaddr_in=32'h0000_1001, vpc=32'h3010 -> req=1. Next cycle: ExcCode=4, BadVAddr=32'h1001, EPC=32'h3010. A simultaneous en with cp0_addr=14 is dropped.
- EXL=1 with exc_code_in=10 -> req=0. Then exl_clr=1 for one cycle -> EXL=0, and the pending exception raises req the next cycle.
- CP0_TIMER_EN, COUNT_DIV=1, SR=32'h0000_8001: mtc0 Count=0 and Compare=5 -> TI=1 on the fifth increment and req=1 via IP[15]. mtc0 Compare=0 -> TI=0. Count at 32'hFFFF_FFFF increments to 0.
- CP0_TIMER_EN undefined: mtc0 Compare=5, then read regs 9 and 11 -> both 0, and req stays 0 indefinitely with hw_int=0.
